// File: rtl/d_cache_mem_port_pkg.sv
// Shared definitions for the cache-to-memory request protocol.
// Holds the request opcode enum used by the memory, I-cache and D-cache ports.
// Also supplies default line/beat sizes when the CPU header has not set them.
`ifndef CACHE_BLOCK_SIZE
`define CACHE_BLOCK_SIZE 128
`endif
`ifndef MEM_TRANS_SIZE
`define MEM_TRANS_SIZE 32
`endif

package d_cache_mem_port_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 16;

    // Request opcode driven by a cache port towards the shared memory.
    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_READ  = 2'd1,
        REQ_WRITE = 2'd2
    } MemReq;

endpackage

// File: rtl/d_cache_request_ifc.sv
// Request channel between the D-cache port and the shared memory block.
// ack is combinational from memory and qualifies the current req.
// Data beats follow an ack one per cycle; there is no per-beat handshake.
interface d_cache_request_ifc
    import d_cache_mem_port_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int BEAT_BITS  = `MEM_TRANS_SIZE
);
    MemReq                 req;
    logic [ADDR_WIDTH-1:0] address;
    logic [BEAT_BITS-1:0]  w_data;
    logic                  ack;
    logic [BEAT_BITS-1:0]  r_data;

    modport cache (output req, output address, output w_data,
                   input ack, input r_data);
    modport mem   (input req, input address, input w_data,
                   output ack, output r_data);
endinterface

// File: rtl/d_cache_mem_port_block_beat_buffer.sv
// Line register shared by write-back (beat read mux) and fill (beat write port).
// Latency: writes land at the next edge; line_next previews the post-edge value.
// No backpressure: the owner sequences load/write strictly one beat per cycle.
module block_beat_buffer #(
    parameter int BLOCK_BITS = 128,
    parameter int BEAT_BITS  = 32,
    parameter int IDX_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [BLOCK_BITS-1:0] load_data,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      idx,
    input  logic [BEAT_BITS-1:0]  wr_data,
    output logic [BEAT_BITS-1:0]  rd_data,
    output logic [BLOCK_BITS-1:0] line_next
);
    logic [BLOCK_BITS-1:0] line_q;
    logic [BLOCK_BITS-1:0] line_d;

    // Whole-line load of the victim wins over a single-beat fill write.
    always_comb begin
        line_d = line_q;
        if (load_en) begin
            line_d = load_data;
        end else if (wr_en) begin
            line_d[idx*BEAT_BITS +: BEAT_BITS] = wr_data;
        end
    end

    assign line_next = line_d;
    assign rd_data   = line_q[idx*BEAT_BITS +: BEAT_BITS];

    // Line storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end
endmodule

// File: rtl/d_cache_mem_port.sv
// D-cache miss engine: optional victim write-back, then line fill from memory.
// Latency: 1 + ack wait + BEATS + 1 cycles to fill_valid, plus 1 + BEATS with write-back.
// Holds req until memory acks; new misses are ignored while busy is high.
module d_cache_mem_port
    import d_cache_mem_port_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int BLOCK_BITS = `CACHE_BLOCK_SIZE,
    parameter int BEAT_BITS  = `MEM_TRANS_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_req,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic                  victim_dirty,
    input  logic [ADDR_WIDTH-1:0] victim_addr,
    input  logic [BLOCK_BITS-1:0] victim_data,
    output logic                  busy,
    output logic                  fill_valid,
    output logic [BLOCK_BITS-1:0] fill_data,
    d_cache_request_ifc.cache     r_mem
);
    localparam int BEATS = BLOCK_BITS / BEAT_BITS;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WB_REQ    = 3'd1;
    localparam logic [2:0] WB_XFER   = 3'd2;
    localparam logic [2:0] FILL_REQ  = 3'd3;
    localparam logic [2:0] FILL_XFER = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [BLOCK_BITS-1:0] fill_data_q, fill_data_d;

    logic                  buf_load;
    logic                  buf_wr;
    logic [BEAT_BITS-1:0]  buf_rd;
    logic [BLOCK_BITS-1:0] buf_line_next;

    // One register holds the victim during write-back, then assembles the fill.
    block_beat_buffer #(
        .BLOCK_BITS (BLOCK_BITS),
        .BEAT_BITS  (BEAT_BITS),
        .IDX_W      (CNT_W)
    ) u_beat_buf (
        .clk       (clk),
        .rst       (rst),
        .load_en   (buf_load),
        .load_data (victim_data),
        .wr_en     (buf_wr),
        .idx       (cnt_q),
        .wr_data   (r_mem.r_data),
        .rd_data   (buf_rd),
        .line_next (buf_line_next)
    );

    // Sequencing: accept miss, optional write-back, fill, one-cycle completion.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        miss_addr_d = miss_addr_q;
        address_d   = address_q;
        fill_data_d = fill_data_q;
        buf_load    = 1'b0;
        buf_wr      = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_req) begin
                    miss_addr_d = miss_addr;
                    buf_load    = 1'b1;
                    if (victim_dirty) begin
                        state_d   = WB_REQ;
                        address_d = victim_addr;
                    end else begin
                        state_d   = FILL_REQ;
                        address_d = miss_addr;
                    end
                end
            end
            WB_REQ: begin
                if (r_mem.ack) begin
                    state_d = WB_XFER;
                    cnt_d   = '0;
                end
            end
            WB_XFER: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BEAT) begin
                    state_d   = FILL_REQ;
                    address_d = miss_addr_q;
                end
            end
            FILL_REQ: begin
                if (r_mem.ack) begin
                    state_d = FILL_XFER;
                    cnt_d   = '0;
                end
            end
            FILL_XFER: begin
                buf_wr = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BEAT) begin
                    // Take the line including the final beat so fill_data is
                    // already complete in the DONE cycle.
                    state_d     = DONE;
                    fill_data_d = buf_line_next;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request opcode and write beat depend only on registered state, so req
    // drops in the cycle after ack.
    always_comb begin
        r_mem.req    = REQ_NONE;
        r_mem.w_data = '0;
        if (state_q == WB_REQ) begin
            r_mem.req = REQ_WRITE;
        end else if (state_q == FILL_REQ) begin
            r_mem.req = REQ_READ;
        end
        if (state_q == WB_XFER) begin
            r_mem.w_data = buf_rd;
        end
    end

    assign r_mem.address = address_q;
    assign busy          = (state_q != IDLE);
    assign fill_valid    = (state_q == DONE);
    assign fill_data     = fill_data_q;

    // State registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            miss_addr_q <= '0;
            address_q   <= '0;
            fill_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            miss_addr_q <= miss_addr_d;
            address_q   <= address_d;
            fill_data_q <= fill_data_d;
        end
    end
endmodule

// File: tb/tb_d_cache_mem_port.sv
// Directed bench for d_cache_mem_port with a behavioural memory on the request channel.
// Each transaction is logged per cycle (cycle 0 = miss_req cycle) and checked by its test.
// Memory ack can be withheld; after a write-back it acks the next read immediately.
module tb_d_cache_mem_port;
    import d_cache_mem_port_pkg::*;

    localparam int NCYC = 20;

    localparam logic [127:0] L01 = 128'h01010101_02020202_03030303_04040404;
    localparam logic [127:0] L02 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] L12 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [127:0] V34 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] V56 = 128'h89ABCDEF_01234567_DEADBEEF_CAFEF00D;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         miss_req = 1'b0;
    logic [15:0]  miss_addr = '0;
    logic         victim_dirty = 1'b0;
    logic [15:0]  victim_addr = '0;
    logic [127:0] victim_data = '0;
    logic         busy;
    logic         fill_valid;
    logic [127:0] fill_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    d_cache_request_ifc #(.ADDR_WIDTH(16), .BEAT_BITS(32)) r_mem_if ();

    d_cache_mem_port dut (
        .clk          (clk),
        .rst          (rst),
        .miss_req     (miss_req),
        .miss_addr    (miss_addr),
        .victim_dirty (victim_dirty),
        .victim_addr  (victim_addr),
        .victim_data  (victim_data),
        .busy         (busy),
        .fill_valid   (fill_valid),
        .fill_data    (fill_data),
        .r_mem        (r_mem_if)
    );

    always #5 clk = ~clk;

    // Behavioural memory.
    logic [127:0] mem [0:255];
    logic         xfer, xfer_wr, post_write;
    logic [7:0]   xaddr;
    int           beat, wait_cnt;
    int           ack_delay = 0;
    logic         ld_en = 1'b0;
    logic [7:0]   ld_addr = '0;
    logic [127:0] ld_line = '0;

    assign r_mem_if.ack = (r_mem_if.req != REQ_NONE) && !xfer &&
                          (post_write || (wait_cnt >= ack_delay));
    assign r_mem_if.r_data = (xfer && !xfer_wr) ? mem[xaddr][beat*32 +: 32] : 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer       <= 1'b0;
            xfer_wr    <= 1'b0;
            post_write <= 1'b0;
            xaddr      <= '0;
            beat       <= 0;
            wait_cnt   <= 0;
        end else begin
            if (ld_en) mem[ld_addr] <= ld_line;
            if (xfer) begin
                if (xfer_wr) mem[xaddr][beat*32 +: 32] <= r_mem_if.w_data;
                if (beat == 3) begin
                    xfer       <= 1'b0;
                    post_write <= xfer_wr;
                end
                beat <= beat + 1;
            end else if (r_mem_if.ack) begin
                xfer       <= 1'b1;
                xfer_wr    <= (r_mem_if.req == REQ_WRITE);
                xaddr      <= r_mem_if.address[7:0];
                beat       <= 0;
                wait_cnt   <= 0;
                post_write <= 1'b0;
            end else if (r_mem_if.req != REQ_NONE) begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    // Per-cycle transaction log.
    MemReq        req_log  [NCYC];
    logic [15:0]  addr_log [NCYC];
    logic [31:0]  wd_log   [NCYC];
    logic         fv_log   [NCYC];
    logic         busy_log [NCYC];
    logic [127:0] fd_log   [NCYC];
    int           fv_cyc, fv_cnt;

    task automatic preload(input logic [7:0] a, input logic [127:0] l);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_line = l;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Drives a miss in cycle 0 and an optional second miss_req pulse in
    // cycle rep_cyc, logging outputs at the negedge of each cycle.
    task automatic run_txn(input logic [15:0] a, input logic d, input logic [15:0] va,
                           input logic [127:0] vd, input int rep_cyc,
                           input logic [15:0] rep_addr);
        fv_cyc = -1;
        fv_cnt = 0;
        @(negedge clk);
        for (int c = 0; c < NCYC; c++) begin
            if (c == 0) begin
                miss_addr = a; victim_dirty = d; victim_addr = va; victim_data = vd;
                miss_req = 1'b1;
            end else if (c == rep_cyc) begin
                miss_addr = rep_addr; victim_dirty = 1'b0; miss_req = 1'b1;
            end else begin
                miss_req = 1'b0;
            end
            req_log[c]  = r_mem_if.req;
            addr_log[c] = r_mem_if.address;
            wd_log[c]   = r_mem_if.w_data;
            fv_log[c]   = fill_valid;
            busy_log[c] = busy;
            fd_log[c]   = fill_data;
            if (fill_valid === 1'b1) begin
                if (fv_cyc < 0) fv_cyc = c;
                fv_cnt++;
            end
            @(negedge clk);
        end
        miss_req = 1'b0;
        victim_dirty = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (fill_valid !== 1'b0) $display("FAIL reset_fill_valid: got %b want 0", fill_valid); else pass_cnt++;
        total_cnt++; if (fill_data !== 128'h0) $display("FAIL reset_fill_data: got %h want 0", fill_data); else pass_cnt++;
        total_cnt++; if (r_mem_if.req !== REQ_NONE) $display("FAIL reset_req: got %0d want %0d", r_mem_if.req, REQ_NONE); else pass_cnt++;
        total_cnt++; if (r_mem_if.address !== 16'h0) $display("FAIL reset_address: got %h want 0", r_mem_if.address); else pass_cnt++;
        total_cnt++; if (r_mem_if.w_data !== 32'h0) $display("FAIL reset_w_data: got %h want 0", r_mem_if.w_data); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_clean_miss;
        int rd_cycles;
        run_txn(16'h0012, 1'b0, 16'h0, 128'h0, -1, 16'h0);
        rd_cycles = 0;
        for (int c = 0; c < NCYC; c++) if (req_log[c] == REQ_READ) rd_cycles++;
        total_cnt++; if (req_log[1] !== REQ_READ) $display("FAIL clean_req: got %0d want %0d", req_log[1], REQ_READ); else pass_cnt++;
        total_cnt++; if (addr_log[1] !== 16'h0012) $display("FAIL clean_addr: got %h want 0012", addr_log[1]); else pass_cnt++;
        total_cnt++; if (rd_cycles !== 1) $display("FAIL clean_read_cycles: got %0d want 1", rd_cycles); else pass_cnt++;
        total_cnt++; if (fv_cyc !== 6) $display("FAIL clean_latency: got %0d want 6", fv_cyc); else pass_cnt++;
        total_cnt++; if (fv_cnt !== 1) $display("FAIL clean_fv_count: got %0d want 1", fv_cnt); else pass_cnt++;
        total_cnt++; if (fd_log[6] !== L12) $display("FAIL clean_data: got %h want %h", fd_log[6], L12); else pass_cnt++;
        total_cnt++; if (busy_log[7] !== 1'b0) $display("FAIL clean_busy_after: got %b want 0", busy_log[7]); else pass_cnt++;
    endtask

    task automatic test_dirty_miss;
        run_txn(16'h0012, 1'b1, 16'h0034, V34, -1, 16'h0);
        total_cnt++; if (req_log[1] !== REQ_WRITE) $display("FAIL dirty_req_write: got %0d want %0d", req_log[1], REQ_WRITE); else pass_cnt++;
        total_cnt++; if (addr_log[1] !== 16'h0034) $display("FAIL dirty_wb_addr: got %h want 0034", addr_log[1]); else pass_cnt++;
        total_cnt++; if (wd_log[2] !== 32'h11111111) $display("FAIL dirty_beat0: got %h want 11111111", wd_log[2]); else pass_cnt++;
        total_cnt++; if (wd_log[3] !== 32'h22222222) $display("FAIL dirty_beat1: got %h want 22222222", wd_log[3]); else pass_cnt++;
        total_cnt++; if (wd_log[4] !== 32'h33333333) $display("FAIL dirty_beat2: got %h want 33333333", wd_log[4]); else pass_cnt++;
        total_cnt++; if (wd_log[5] !== 32'h44444444) $display("FAIL dirty_beat3: got %h want 44444444", wd_log[5]); else pass_cnt++;
        total_cnt++; if (req_log[6] !== REQ_READ) $display("FAIL dirty_req_read: got %0d want %0d", req_log[6], REQ_READ); else pass_cnt++;
        total_cnt++; if (addr_log[6] !== 16'h0012) $display("FAIL dirty_fill_addr: got %h want 0012", addr_log[6]); else pass_cnt++;
        total_cnt++; if (req_log[7] !== REQ_NONE) $display("FAIL dirty_read_one_cycle: got %0d want %0d", req_log[7], REQ_NONE); else pass_cnt++;
        total_cnt++; if (fv_cyc !== 11) $display("FAIL dirty_latency: got %0d want 11", fv_cyc); else pass_cnt++;
        total_cnt++; if (fd_log[11] !== L12) $display("FAIL dirty_data: got %h want %h", fd_log[11], L12); else pass_cnt++;
        total_cnt++; if (mem[8'h34] !== V34) $display("FAIL dirty_mem_victim: got %h want %h", mem[8'h34], V34); else pass_cnt++;
    endtask

    task automatic test_ack_delay;
        int wr_cycles, addr_ok;
        ack_delay = 5;
        run_txn(16'h0012, 1'b1, 16'h0056, V56, -1, 16'h0);
        ack_delay = 0;
        wr_cycles = 0;
        addr_ok = 0;
        for (int c = 0; c < NCYC; c++) if (req_log[c] == REQ_WRITE) wr_cycles++;
        for (int c = 1; c <= 6; c++) if (addr_log[c] == 16'h0056) addr_ok++;
        total_cnt++; if (wr_cycles !== 6) $display("FAIL delay_write_held: got %0d want 6", wr_cycles); else pass_cnt++;
        total_cnt++; if (addr_ok !== 6) $display("FAIL delay_addr_stable: got %0d want 6", addr_ok); else pass_cnt++;
        total_cnt++; if (req_log[7] !== REQ_NONE) $display("FAIL delay_req_drop: got %0d want %0d", req_log[7], REQ_NONE); else pass_cnt++;
        total_cnt++; if (wd_log[7] !== 32'hCAFEF00D) $display("FAIL delay_beat0: got %h want CAFEF00D", wd_log[7]); else pass_cnt++;
        total_cnt++; if (wd_log[10] !== 32'h89ABCDEF) $display("FAIL delay_beat3: got %h want 89ABCDEF", wd_log[10]); else pass_cnt++;
        total_cnt++; if (fv_cyc !== 16) $display("FAIL delay_latency: got %0d want 16", fv_cyc); else pass_cnt++;
        total_cnt++; if (fd_log[16] !== L12) $display("FAIL delay_data: got %h want %h", fd_log[16], L12); else pass_cnt++;
        total_cnt++; if (mem[8'h56] !== V56) $display("FAIL delay_mem_victim: got %h want %h", mem[8'h56], V56); else pass_cnt++;
    endtask

    task automatic test_busy_ignore;
        run_txn(16'h0012, 1'b0, 16'h0, 128'h0, 3, 16'h0001);
        total_cnt++; if (fv_cnt !== 1) $display("FAIL busy_fv_count: got %0d want 1", fv_cnt); else pass_cnt++;
        total_cnt++; if (fv_cyc !== 6) $display("FAIL busy_latency: got %0d want 6", fv_cyc); else pass_cnt++;
        total_cnt++; if (fd_log[6] !== L12) $display("FAIL busy_data: got %h want %h", fd_log[6], L12); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        // Second miss is presented in cycle 7, the first IDLE cycle.
        run_txn(16'h0001, 1'b0, 16'h0, 128'h0, 7, 16'h0002);
        total_cnt++; if (fv_cnt !== 2) $display("FAIL b2b_fv_count: got %0d want 2", fv_cnt); else pass_cnt++;
        total_cnt++; if (fv_log[6] !== 1'b1) $display("FAIL b2b_fv_first: got %b want 1", fv_log[6]); else pass_cnt++;
        total_cnt++; if (fd_log[6] !== L01) $display("FAIL b2b_data_first: got %h want %h", fd_log[6], L01); else pass_cnt++;
        total_cnt++; if (busy_log[7] !== 1'b0) $display("FAIL b2b_idle_gap: got %b want 0", busy_log[7]); else pass_cnt++;
        total_cnt++; if (fd_log[10] !== L01) $display("FAIL b2b_data_held: got %h want %h", fd_log[10], L01); else pass_cnt++;
        total_cnt++; if (fv_log[13] !== 1'b1) $display("FAIL b2b_fv_second: got %b want 1", fv_log[13]); else pass_cnt++;
        total_cnt++; if (fd_log[13] !== L02) $display("FAIL b2b_data_second: got %h want %h", fd_log[13], L02); else pass_cnt++;
    endtask

    task automatic test_reset_mid_fill;
        int fv_seen;
        @(negedge clk);
        miss_addr = 16'h0012; victim_dirty = 1'b0; miss_req = 1'b1;
        @(negedge clk);
        miss_req = 1'b0;
        repeat (3) @(negedge clk);
        // Now in cycle 4: FILL_XFER beat 2.
        total_cnt++; if (busy !== 1'b1) $display("FAIL rstmid_pre_busy: got %b want 1", busy); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (fill_valid !== 1'b0) $display("FAIL rstmid_fill_valid: got %b want 0", fill_valid); else pass_cnt++;
        total_cnt++; if (fill_data !== 128'h0) $display("FAIL rstmid_fill_data: got %h want 0", fill_data); else pass_cnt++;
        total_cnt++; if (r_mem_if.req !== REQ_NONE) $display("FAIL rstmid_req: got %0d want %0d", r_mem_if.req, REQ_NONE); else pass_cnt++;
        total_cnt++; if (r_mem_if.address !== 16'h0) $display("FAIL rstmid_address: got %h want 0", r_mem_if.address); else pass_cnt++;
        fv_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (fill_valid !== 1'b0) fv_seen++;
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (fill_valid !== 1'b0) fv_seen++;
        end
        total_cnt++; if (fv_seen !== 0) $display("FAIL rstmid_no_fill_valid: got %0d pulses want 0", fv_seen); else pass_cnt++;
        total_cnt++; if (fill_data !== 128'h0) $display("FAIL rstmid_data_after: got %h want 0", fill_data); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        preload(8'h01, L01);
        preload(8'h02, L02);
        preload(8'h12, L12);
        test_clean_miss();
        test_dirty_miss();
        test_ack_delay();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/d_cache_mem_port.md
Name: d_cache_mem_port

Overview:
- Cache-side initiator of the data-cache-to-memory request protocol.
- Takes one miss from the D-cache core (optional dirty victim plus a line to fill).
- Write-back: issues REQ_WRITE and streams the victim block out as BEAT_BITS beats. Fill: issues REQ_READ and collects the beats into a full line.
- Returns the line to the cache core with a one-cycle valid pulse. Sits between the D-cache tag/data arrays and the shared memory block.

Parameters:
- ADDR_WIDTH, 16: block address width on the memory interface.
- BLOCK_BITS, `CACHE_BLOCK_SIZE: cache line width.
- BEAT_BITS, `MEM_TRANS_SIZE: width of one memory transfer; BLOCK_BITS must be an exact multiple.
- BEATS, BLOCK_BITS/BEAT_BITS (derived, must be a power of two ≥2): beats per block.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- miss_req  in  1  cache core requests service; sampled only in IDLE
- miss_addr  in  ADDR_WIDTH  block address to fill
- victim_dirty  in  1  write back the victim first
- victim_addr  in  ADDR_WIDTH  victim block address
- victim_data  in  BLOCK_BITS  victim line
- busy  out  1  high in every state except IDLE
- fill_valid  out  1  one-cycle pulse when fill_data is complete
- fill_data  out  BLOCK_BITS  filled line; held until the next fill completes
- r_mem  d_cache_request_ifc.cache  —  drives req (MemReq), address (ADDR_WIDTH), w_data (BEAT_BITS); receives ack (1), r_data (BEAT_BITS)

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, fill_valid=0, fill_data=0, req=REQ_NONE, address=0, w_data=0, beat counter=0.
- IDLE: if miss_req=1, latch miss_addr, victim_dirty, victim_addr and victim_data. Go to WB_REQ if victim_dirty=1, else FILL_REQ. miss_req in any other state is ignored; the core must wait for busy=0.
- WB_REQ:
  - Drive req=REQ_WRITE and address=victim_addr.
  - Hold req until the cycle in which ack=1 (ack is combinational and may be delayed any number of cycles while memory serves the I-cache).
  - On ack go to WB_XFER with counter=0.
- WB_XFER:
  - In the k-th cycle after ack (k=0..BEATS-1), drive w_data=victim[k*BEAT_BITS +: BEAT_BITS] and keep address=victim_addr. Beat 0 is the low slice.
  - req=REQ_NONE throughout; memory samples w_data at each edge.
  - After beat BEATS-1 go to FILL_REQ.
- FILL_REQ:
  - Drive req=REQ_READ and address=miss_addr; hold until ack.
  - After a write-back, memory sits in its post-write ready state and acks REQ_READ immediately; otherwise ack may be delayed.
  - On ack go to FILL_XFER with counter=0.
- FILL_XFER:
  - req=REQ_NONE, address=miss_addr.
  - In the k-th cycle after ack, r_data is beat k; capture it at that cycle's edge into the assembly register slice k.
  - After beat BEATS-1 go to DONE.
- DONE: copy the assembly register to fill_data, pulse fill_valid=1 for exactly one cycle, and return to IDLE.
- Latency:
  - No write-back: 1 (IDLE) + ack wait + BEATS + 1 cycles from miss_req to fill_valid.
  - With write-back: add 1 + BEATS.
- req never stays asserted in the cycle after ack; a lingering req would cause a spurious re-ack.
- Counter width is log2(BEATS) and wraps naturally. Completion is detected at counter==BEATS-1, not on overflow.
- Reset mid-transfer aborts the operation; no partial fill_valid is produced. Memory holds no reset, so system reset must cover both blocks together.

Decomposition:
- Shared package: MemReq enum {REQ_NONE, REQ_READ, REQ_WRITE}, shared with the memory and I-cache port.
- Local MemPortState enum {IDLE, WB_REQ, WB_XFER, FILL_REQ, FILL_XFER, DONE}.
- Macros `CACHE_BLOCK_SIZE and `MEM_TRANS_SIZE come from nand_cpu.svh.
- One natural sub-module: block_beat_buffer. It is a BLOCK_BITS register with a beat-indexed write port (fill) and a beat-indexed read mux (write-back).

Test Plan (BLOCK_BITS=128, BEAT_BITS=32, BEATS=4):
- Clean miss, addr 0x0012, memory line 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, immediate ack -> req=REQ_READ for 1 cycle; fill_valid 6 cycles after miss_req; fill_data matches; busy back to 0 the next cycle.
- Dirty miss, victim 0x0034 = 0x44..._33..._22..._11..., fill 0x0012 -> w_data beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 in consecutive cycles. Memory line 0x0034 then holds the victim. REQ_READ is acked in the cycle after the last beat; fill correct.
- Ack withheld 5 cycles (I-cache busy) -> req held at REQ_WRITE and address stable for all 5 cycles; the beat sequence starts exactly one cycle after ack.
- miss_req pulsed again while busy -> ignored; exactly one fill_valid is produced. A new miss accepted the cycle after return to IDLE completes normally.
- rst asserted during FILL_XFER beat 2 -> outputs immediately at reset values; no fill_valid; fill_data=0.
- Back-to-back clean misses 0x0001 then 0x0002 -> two fill_valid pulses with distinct correct lines; fill_data held stable between them.
